// File: rtl/alu_serial_seq_if.sv
// Bus between the serial sequencer, its datapath controller and the 1-bit ALU slice.
// The slave modport is the sequencer. The master modport is the environment, meaning the controller plus the slice.
interface alu_serial_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             slice_a;
  logic             slice_b;
  logic             slice_binvert;
  logic             slice_cin;
  logic [2:0]       slice_op;
  logic             slice_result;
  logic             slice_cout;

  modport master (
    output start, op, a, b, slice_result, slice_cout,
    input  busy, done, result, carry_out, overflow, zero,
           slice_a, slice_b, slice_binvert, slice_cin, slice_op
  );

  modport slave (
    input  start, op, a, b, slice_result, slice_cout,
    output busy, done, result, carry_out, overflow, zero,
           slice_a, slice_b, slice_binvert, slice_cin, slice_op
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer that pushes a WIDTH-bit operation through a single 1-bit ALU slice.
// Operands are processed LSB first. The result is assembled from the slice outputs, and flags are derived on the last bit.
module alu_serial_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input logic              clk,
  input logic              reset,
  alu_serial_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] aSh_q;
  logic [WIDTH-1:0] bSh_q;
  logic [WIDTH-1:0] resSh_q;
  logic [WIDTH-1:0] resSh_d;
  logic [CNT_W-1:0] count_q;
  logic             carry_q;
  logic [2:0]       opLat_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             carryOut_q;
  logic             overflow_q;
  logic             zero_q;
  logic             isArith;

  assign resSh_d = {bus.slice_result, resSh_q[WIDTH-1:1]};

  // 101 and 111 fall through to the adder. 101 acts as ADD and 111 acts as SUB.
  assign isArith = (opLat_q[1:0] == 2'b10) || (opLat_q[2] && opLat_q[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      aSh_q      <= '0;
      bSh_q      <= '0;
      resSh_q    <= '0;
      count_q    <= '0;
      carry_q    <= 1'b0;
      opLat_q    <= 3'b000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      carryOut_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            aSh_q   <= bus.a;
            bSh_q   <= bus.b;
            opLat_q <= bus.op;
            count_q <= '0;
            carry_q <= bus.op[2] & bus.op[1];
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          resSh_q <= resSh_d;
          carry_q <= bus.slice_cout;
          aSh_q   <= aSh_q >> 1;
          bSh_q   <= bSh_q >> 1;
          count_q <= count_q + CNT_W'(1);
          // On the last bit, carry_q still holds the carry into the MSB.
          if (count_q == LastCount) begin
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            result_q   <= resSh_d;
            carryOut_q <= isArith & bus.slice_cout;
            overflow_q <= isArith & (carry_q ^ bus.slice_cout);
            zero_q     <= (resSh_d == '0);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.result        = result_q;
  assign bus.carry_out     = carryOut_q;
  assign bus.overflow      = overflow_q;
  assign bus.zero          = zero_q;
  assign bus.slice_a       = (state_q == RUN) ? aSh_q[0] : 1'b0;
  assign bus.slice_b       = (state_q == RUN) ? bSh_q[0] : 1'b0;
  assign bus.slice_binvert = opLat_q[2] & opLat_q[1];
  assign bus.slice_cin     = carry_q;
  assign bus.slice_op      = opLat_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq.
// It models the 1-bit slice, checks results against a whole-word reference model through a scoreboard, and mixes directed and random operations.
module tb_alu_serial_seq;

  localparam int W = 8;

  localparam logic [2:0] OpAnd  = 3'b000;
  localparam logic [2:0] OpOr   = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpSub  = 3'b110;
  localparam logic [2:0] OpNand = 3'b011;
  localparam logic [2:0] OpNor  = 3'b100;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;
  int   busyCycles;
  bit   prevDone;
  exp_t expQ[$];

  alu_serial_seq_if #(.WIDTH(W)) bus ();

  alu_serial_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1-bit ALU slice sitting downstream of the sequencer.
  always_comb begin
    logic bb;
    bb = bus.slice_b ^ bus.slice_binvert;
    case (bus.slice_op)
      3'b000:  bus.slice_result = bus.slice_a & bb;
      3'b001:  bus.slice_result = bus.slice_a | bb;
      3'b011:  bus.slice_result = ~(bus.slice_a & bb);
      3'b100:  bus.slice_result = ~(bus.slice_a | bb);
      default: bus.slice_result = bus.slice_a ^ bb ^ bus.slice_cin;
    endcase
    bus.slice_cout = (bus.slice_a & bb) | (bus.slice_a & bus.slice_cin) | (bb & bus.slice_cin);
  end

  function automatic exp_t refModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t     e;
    logic [W:0] sum;
    e.cout = 1'b0;
    e.ovf  = 1'b0;
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b011: e.res = ~(a & b);
      3'b100: e.res = ~(a | b);
      3'b010, 3'b101: begin
        sum    = {1'b0, a} + {1'b0, b};
        e.res  = sum[W-1:0];
        e.cout = sum[W];
        e.ovf  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      default: begin
        sum    = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        e.res  = sum[W-1:0];
        e.cout = sum[W];
        e.ovf  = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Issue one operation, then check the slice drive on the first RUN cycle.
  task automatic applyStimulus(input logic [2:0] opIn, input logic [W-1:0] aIn, input logic [W-1:0] bIn);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("idleBeforeStart", {30'd0, bus.busy, bus.done}, 32'd0);
    bus.start = 1'b1;
    bus.op    = opIn;
    bus.a     = aIn;
    bus.b     = bIn;
    expQ.push_back(refModel(opIn, aIn, bIn));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("firstRunBusy", {31'd0, bus.busy}, 32'd1);
    checkOutput("firstRunSliceA", {31'd0, bus.slice_a}, {31'd0, aIn[0]});
    checkOutput("firstRunSliceB", {31'd0, bus.slice_b}, {31'd0, bIn[0]});
    checkOutput("firstRunBinvert", {31'd0, bus.slice_binvert}, {31'd0, opIn[2] & opIn[1]});
    checkOutput("firstRunCin", {31'd0, bus.slice_cin}, {31'd0, opIn[2] & opIn[1]});
    checkOutput("firstRunSliceOp", {29'd0, bus.slice_op}, {29'd0, opIn});
  endtask

  // Wait for done, counting edges since the accepting edge. Entry is at #1 after edge 'already'.
  task automatic waitDone(input int already);
    int k;
    k = already;
    while (k < W + 6) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.done) break;
    end
    checkOutput("doneLatency", k, W);
  endtask

  // Scoreboard monitor: compare each done pulse against the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busyCycles = 0;
      prevDone   = 1'b0;
    end else begin
      if (bus.busy) busyCycles++;
      if (bus.done) begin
        checkOutput("doneSinglePulse", {31'd0, prevDone}, 32'd0);
        checkOutput("busyLength", busyCycles, W);
        checkOutput("busyLowInDone", {31'd0, bus.busy}, 32'd0);
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpectedDone: actual=done with empty scoreboard required=no done");
        end else begin
          e = expQ.pop_front();
          checkOutput("result", {24'd0, bus.result}, {24'd0, e.res});
          checkOutput("carryOut", {31'd0, bus.carry_out}, {31'd0, e.cout});
          checkOutput("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
          checkOutput("zero", {31'd0, bus.zero}, {31'd0, e.zero});
        end
        busyCycles = 0;
      end
      prevDone = bus.done;
    end
  end

  initial begin
    logic [2:0] opTable [8];
    logic [W-1:0] edgeVals [4];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit sawDone;
    int guard;
    opTable  = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b011, 3'b100, 3'b101, 3'b111};
    edgeVals = '{8'h00, 8'hFF, 8'h80, 8'h7F};
    assertCount = 0;
    failCount   = 0;
    busyCycles  = 0;
    prevDone    = 1'b0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("resetDone", {31'd0, bus.done}, 32'd0);
    checkOutput("resetFlags", {24'd0, bus.result, bus.carry_out, bus.overflow, bus.zero, 5'd0}, 32'd0);
    checkOutput("resetSlice", {25'd0, bus.slice_a, bus.slice_b, bus.slice_binvert, bus.slice_cin, bus.slice_op}, 32'd0);
    reset = 1'b0;

    $display("[TB] directed operations");
    applyStimulus(OpAdd, 8'h7F, 8'h01);  waitDone(0);
    applyStimulus(OpSub, 8'h05, 8'h05);  waitDone(0);
    applyStimulus(OpAnd, 8'hF0, 8'h3C);  waitDone(0);
    applyStimulus(OpNor, 8'h0F, 8'hF0);  waitDone(0);
    applyStimulus(OpSub, 8'h80, 8'h01);  waitDone(0);
    applyStimulus(OpAdd, 8'hFF, 8'h01);  waitDone(0);
    applyStimulus(OpNand, 8'hFF, 8'hFF); waitDone(0);
    applyStimulus(OpOr, 8'h00, 8'h00);   waitDone(0);

    $display("[TB] start pulse during RUN is ignored");
    applyStimulus(OpAdd, 8'h01, 8'h02);
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = OpOr;
    bus.a     = 8'hFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone(3);

    $display("[TB] reset in the middle of an operation");
    applyStimulus(OpSub, 8'h33, 8'h11);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expQ.delete();
    checkOutput("midResetBusyDone", {30'd0, bus.busy, bus.done}, 32'd0);
    checkOutput("midResetFlags", {24'd0, bus.result, bus.carry_out, bus.overflow, bus.zero, 5'd0}, 32'd0);
    checkOutput("midResetSlice", {25'd0, bus.slice_a, bus.slice_b, bus.slice_binvert, bus.slice_cin, bus.slice_op}, 32'd0);
    sawDone = 1'b0;
    repeat (W + 2) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) sawDone = 1'b1;
    end
    checkOutput("noActivityAfterReset", {31'd0, sawDone}, 32'd0);
    applyStimulus(OpAdd, 8'h12, 8'h34); waitDone(0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 3)] : W'($urandom);
      applyStimulus(opTable[$urandom_range(0, 7)], ra, rb);
      waitDone(0);
    end

    guard = 0;
    while (expQ.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    checkOutput("scoreboardDrained", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
